wide_add_sequencer: RTL and testbench
=====================================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 4, giving the number of 32-bit words per operand (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept an operand request.
REQ-006 in_a  input  32*N_WORDS  operand A; word k is bits [32k+31:32k].
REQ-007 in_b  input  32*N_WORDS  operand B, same word layout as in_a.
REQ-008 in_cin  input  1  carry-in to the least significant word.
REQ-009 add_in1  output  32  current A word, driven to the external 32-bit adder.
REQ-010 add_in2  output  32  current B word, driven to the external adder.
REQ-011 add_c_in  output  1  carry into the external adder.
REQ-012 add_sum  input  32  external adder sum, combinational from add_in1/add_in2/add_c_in.
REQ-013 add_c_out  input  1  external adder carry-out, combinational.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_sum  output  32*N_WORDS  full-width sum, same word layout as in_a.
REQ-017 out_c_out  output  1  carry-out of the most significant word.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 in_ready SHALL be 1 in IDLE, 1 in DONE while out_ready=1, and 0 otherwise.
REQ-021 An accept (in_valid & in_ready at an edge) SHALL latch in_a, in_b and in_cin, clear the word index to 0, and enter RUN.
REQ-022 In RUN: add_in1/add_in2 = latched word[idx]; add_c_in = carry register; carry register loads in_cin at accept.
REQ-023 Each RUN edge: sum_reg word[idx] <= add_sum; carry register <= add_c_out; idx <= idx+1.
REQ-024 The RUN edge with idx = N_WORDS-1 SHALL capture the last word and enter DONE; the index SHALL never wrap.
REQ-025 Latency: out_valid SHALL rise exactly N_WORDS cycles after the accept edge.
REQ-026 In DONE: out_valid=1; out_sum = sum_reg; out_c_out = final carry; both held stable until out_valid & out_ready.
REQ-027 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE on the next edge.
REQ-028 DONE with out_ready=1 and in_valid=1 (simultaneous handoff) SHALL complete the result and accept the new request on the same edge, entering RUN; there is no bubble.
REQ-029 In IDLE and DONE, add_in1, add_in2 and add_c_in SHALL be driven to 0.
REQ-030 out_valid SHALL be 0 in IDLE and RUN; out_sum and out_c_out SHALL retain their last values there.
REQ-031 in_valid in RUN SHALL be ignored (no accept), and in_a/in_b changes SHALL not affect the operation in flight.
REQ-032 All arithmetic SHALL be modulo 2^(32*N_WORDS); overflow appears only on out_c_out.

Reset
REQ-033 rst_n low SHALL immediately force:
- state IDLE, idx 0;
- all operand, sum and carry registers 0;
- out_valid 0, busy 0, out_sum 0, out_c_out 0, add_in1/add_in2/add_c_in 0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result ever presented; in_ready=1 on the first cycle after release.

Verification (N_WORDS=4, behavioural 32-bit adder model on add_*)
REQ-035 Zero add: A=0, B=0, cin=0 -> out_valid 4 cycles after accept, out_sum=0, out_c_out=0.
REQ-036 Full carry ripple: A=all-ones (128 bits), B=0, cin=1 -> out_sum=0, out_c_out=1, add_c_in=1 on every RUN cycle.
REQ-037 Word-boundary carry: A=0x0000_FFFFFFFF (word0 all-ones), B=1, cin=0 -> out_sum=0x1_00000000, out_c_out=0.
REQ-038 Backpressure and back-to-back:
- hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_sum stable, in_ready=0;
- then raise out_ready with in_valid=1 -> next request accepted that edge, out_valid for it 4 cycles later.
REQ-039 Reset mid-operation: assert rst_n=0 during RUN at idx=2 -> all outputs 0 immediately; after release in_ready=1 and no out_valid until a new accept.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-word adder sequencer: streams N_WORDS operand words through one external
// 32-bit adder, rippling the carry word by word, and presents the full-width sum.
module wide_add_sequencer #(
  parameter int N_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*N_WORDS-1:0]  in_a,
  input  logic [32*N_WORDS-1:0]  in_b,
  input  logic                   in_cin,
  output logic [31:0]            add_in1,
  output logic [31:0]            add_in2,
  output logic                   add_c_in,
  input  logic [31:0]            add_sum,
  input  logic                   add_c_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*N_WORDS-1:0]  out_sum,
  output logic                   out_c_out,
  output logic                   busy
);

  localparam int W     = 32 * N_WORDS;
  localparam int IDX_W = $clog2(N_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [W-1:0]     a_reg, b_reg;
  logic [W-1:0]     sum_reg, sum_next;
  logic [W-1:0]     out_sum_reg;
  logic             carry_reg;
  logic             out_cout_reg;

  logic             run, done, last, accept;
  logic [31:0]      a_words [N_WORDS];
  logic [31:0]      b_words [N_WORDS];

  assign run    = (state_reg == S_RUN);
  assign done   = (state_reg == S_DONE);
  assign last   = (idx_reg == IDX_W'(N_WORDS - 1));
  assign accept = in_valid & in_ready;

  // Word views of the latched operands, and the running sum with the current
  // word replaced by the adder result.
  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_word
      assign a_words[gi] = a_reg[32*gi +: 32];
      assign b_words[gi] = b_reg[32*gi +: 32];
      assign sum_next[32*gi +: 32] = (run && idx_reg == IDX_W'(gi)) ? add_sum
                                                                     : sum_reg[32*gi +: 32];
    end
  endgenerate

  assign in_ready  = (state_reg == S_IDLE) | (done & out_ready);
  assign busy      = (state_reg != S_IDLE);
  assign out_valid = done;
  assign out_sum   = out_sum_reg;
  assign out_c_out = out_cout_reg;
  assign add_in1   = run ? a_words[idx_reg] : 32'd0;
  assign add_in2   = run ? b_words[idx_reg] : 32'd0;
  assign add_c_in  = run & carry_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (accept) begin
      state_next = S_RUN;
      idx_next   = '0;
    end else if (run) begin
      if (last) state_next = S_DONE;
      else      idx_next   = idx_reg + IDX_W'(1);
    end else if (done && out_ready) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      out_sum_reg  <= '0;
      out_cout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (accept) begin
        a_reg     <= in_a;
        b_reg     <= in_b;
        carry_reg <= in_cin;
      end else if (run) begin
        sum_reg   <= sum_next;
        carry_reg <= add_c_out;
        // The output copy only moves on completion so it stays stable otherwise.
        if (last) begin
          out_sum_reg  <= sum_next;
          out_cout_reg <= add_c_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomised and directed bench for wide_add_sequencer with a behavioural 32-bit
// adder on the add_* port and a full-width arithmetic reference model.
module tb_wide_add_sequencer;
  localparam int N = 4;
  localparam int W = 32 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic [31:0]   add_in1, add_in2, add_sum;
  logic          add_c_in, add_c_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_c_out;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.N_WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_in1(add_in1), .add_in2(add_in2), .add_c_in(add_c_in),
    .add_sum(add_sum), .add_c_out(add_c_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_c_out(out_c_out), .busy(busy)
  );

  // Behavioural external adder
  assign {add_c_out, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {32'd0, add_c_in};

  task automatic check(input string nm, input logic [W:0] got, input logic [W:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  // Reference model: a job is accepted, its result is due N edges later, and
  // it stays presented until consumed.
  bit          m_have = 1'b0;
  int          m_age = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic        m_cin = 1'b0;
  logic [W:0]  m_job = '0;
  logic [W:0]  m_disp = '0;

  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    logic [W:0] m, p;
    m = ({{W{1'b0}}, 1'b1} << (32 * k)) - 1'b1;
    p = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
    return p[32 * k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit dv, rdy;
    if (!rst_n) begin
      m_have = 1'b0;
      m_age  = 0;
      m_disp = '0;
    end else begin
      dv  = m_have && (m_age >= N);
      rdy = !m_have || (dv && out_ready);
      if (dv && out_ready) begin
        m_have = 1'b0;
        m_disp = m_job;
        n_txn++;
        $display("txn %0d: sum=%h cout=%b", n_txn, m_job[W-1:0], m_job[W]);
      end else if (m_have) begin
        m_age++;
      end
      if (in_valid && rdy) begin
        m_have = 1'b1;
        m_age  = 0;
        m_a    = in_a;
        m_b    = in_b;
        m_cin  = in_cin;
        m_job  = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
      end
    end
  end

  always @(negedge clk) begin
    bit ev, er;
    logic [W:0] es;
    if (!rst_n) begin
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in1", add_in1, 0);
      check("rst_in2", add_in2, 0);
      check("rst_cin", add_c_in, 0);
      check("rst_sum", out_sum, 0);
      check("rst_cout", out_c_out, 0);
    end else begin
      ev = m_have && (m_age >= N);
      er = m_have && (m_age < N);
      check("out_valid", out_valid, ev);
      check("busy", busy, m_have);
      check("in_ready", in_ready, !m_have || (ev && out_ready));
      check("add_in1", add_in1, er ? m_a[32*m_age +: 32] : 32'd0);
      check("add_in2", add_in2, er ? m_b[32*m_age +: 32] : 32'd0);
      check("add_c_in", add_c_in, er ? carry_into(m_a, m_b, m_cin, m_age) : 1'b0);
      es = ev ? m_job : m_disp;
      check("out_sum", out_sum, es[W-1:0]);
      check("out_c_out", out_c_out, es[W]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit chk_cin, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (chk_cin) check("ripple_cin", add_c_in, 1);
      step();
      lat++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input bit chk_cin,
                       input bit hold);
    int n, lat;
    out_ready = !hold;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("ready_timeout", in_ready, 1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = {$urandom, $urandom, $urandom, $urandom};
    in_b = {$urandom, $urandom, $urandom, $urandom};
    wait_done(chk_cin, lat);
    check("latency", lat, N);
    check("lit_sum", out_sum, es);
    check("lit_cout", out_c_out, ec);
    if (!hold) step();
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0:       v[32*k +: 32] = 32'd0;
        1:       v[32*k +: 32] = 32'hFFFF_FFFF;
        default: v[32*k +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  initial begin
    int lat;
    logic [W-1:0] ones;
    ones = '1;

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("init_ready", in_ready, 1);
    check("init_valid", out_valid, 0);
    check("init_busy", busy, 0);

    do_op('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    do_op(ones, '0, 1'b1, '0, 1'b1, 1'b1, 1'b0);
    do_op(128'hFFFF_FFFF, 128'h1, 1'b0, 128'h1_0000_0000, 1'b0, 1'b0, 1'b0);
    do_op(ones, ones, 1'b1, ones, 1'b1, 1'b0, 1'b0);

    // Backpressure in DONE, then a same-edge handoff to the next request
    do_op(128'h1, 128'h2, 1'b1, 128'h4, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_a = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
    in_b = 128'h0000_0001_0000_0000_0000_0001_0000_0000;
    in_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 128'h4);
      check("bp_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(1'b0, lat);
    check("handoff_latency", lat, N);
    check("handoff_sum", out_sum, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    check("handoff_cout", out_c_out, 1);
    step();

    // Asynchronous reset while RUN is at word index 2
    in_a = rand_op(); in_b = rand_op(); in_cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in1", add_in1, 0);
    check("abort_cin", add_c_in, 0);
    check("abort_sum", out_sum, 0);
    check("abort_cout", out_c_out, 0);
    step();
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_novalid", out_valid, 0);
    end

    // Randomised traffic, including operand churn during RUN and rare reset pulses
    for (int i = 0; i < 600; i++) begin
      step();
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      in_cin    = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
